multicycle_ctrl: RTL and testbench

- Multicycle control unit: state machine sequencing every instruction through IF/ID/EXE/MEM/WB.
- Sits directly downstream of the instruction register and consumes its opcode field (Instr[31:26]).
- Generates IRWre back to the instruction register, plus PC, register-file, ALU and data-memory controls.
- Outputs are combinational from the current state, Opcode and ALU flags; only the state is registered.

---
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit. Sequences each instruction through
// IF/ID/EXE/MEM/WB and decodes datapath controls from the current state,
// the IR opcode field and the ALU flags. Only the state is registered;
// every control output is a combinational function of those inputs.
module multicycle_ctrl #(
   parameter int unsigned     OP_W    = 6,
   parameter logic [OP_W-1:0] HALT_OP = 6'b111111
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic [OP_W-1:0] Opcode,
   input  logic            Zero,
   input  logic            Sign,
   output logic            PCWre,
   output logic            IRWre,
   output logic            InsMemRW,
   output logic            ExtSel,
   output logic [1:0]      RegDst,
   output logic            RegWre,
   output logic            WrRegDSrc,
   output logic            ALUSrcA,
   output logic            ALUSrcB,
   output logic [2:0]      ALUOp,
   output logic [1:0]      PCSrc,
   output logic            mRD,
   output logic            mWR,
   output logic            DBDataSrc,
   output logic [3:0]      State
);

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EXE_AL = 4'd2,
      S_WB_AL  = 4'd3,
      S_EXE_BR = 4'd4,
      S_EXE_LS = 4'd5,
      S_MEM    = 4'd6,
      S_WB_L   = 4'd7,
      S_HLT    = 4'd8
   } state_t;

   localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
   localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
   localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
   localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
   localparam logic [OP_W-1:0] OP_SLT   = 6'b100110;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b100111;
   localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
   localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
   localparam logic [OP_W-1:0] OP_J     = 6'b111000;
   localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;

   state_t state_q, state_d;

   logic is_rtype, is_itype, is_alu, is_branch, is_ls, is_jump, is_halt;
   logic uses_imm, zero_ext;
   logic [2:0] alu_dec;

   // Opcode class decode shared by the next-state and output logic
   always_comb begin
      is_rtype  = (Opcode == OP_ADD) || (Opcode == OP_SUB) || (Opcode == OP_AND) ||
                  (Opcode == OP_SLL) || (Opcode == OP_SLT);
      is_itype  = (Opcode == OP_ADDIU) || (Opcode == OP_ANDI) || (Opcode == OP_ORI) ||
                  (Opcode == OP_SLTI);
      is_alu    = is_rtype || is_itype;
      is_branch = (Opcode == OP_BEQ) || (Opcode == OP_BNE) || (Opcode == OP_BLTZ);
      is_ls     = (Opcode == OP_SW) || (Opcode == OP_LW);
      is_jump   = (Opcode == OP_J) || (Opcode == OP_JAL) || (Opcode == OP_JR);
      is_halt   = (Opcode == HALT_OP);
      uses_imm  = is_itype || is_ls;
      zero_ext  = (Opcode == OP_ANDI) || (Opcode == OP_ORI);
      unique case (Opcode)
         OP_SUB:           alu_dec = 3'b001;
         OP_SLL:           alu_dec = 3'b010;
         OP_ORI:           alu_dec = 3'b011;
         OP_AND, OP_ANDI:  alu_dec = 3'b100;
         OP_SLT, OP_SLTI:  alu_dec = 3'b110;
         default:          alu_dec = 3'b000;
      endcase
   end

   // State register with synchronous active-low reset back to IF
   always_ff @(posedge clk) begin
      if (!Reset) state_q <= S_IF;
      else        state_q <= state_d;
   end

   // Next-state sequencing; undefined opcodes fall back to IF as a NOP
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IF:     state_d = S_ID;
         S_ID: begin
            if (is_halt)        state_d = S_HLT;
            else if (is_branch) state_d = S_EXE_BR;
            else if (is_ls)     state_d = S_EXE_LS;
            else if (is_alu)    state_d = S_EXE_AL;
            else                state_d = S_IF;
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_WB_AL:  state_d = S_IF;
         S_EXE_BR: state_d = S_IF;
         S_EXE_LS: state_d = S_MEM;
         S_MEM:    state_d = (Opcode == OP_LW) ? S_WB_L : S_IF;
         S_WB_L:   state_d = S_IF;
         S_HLT:    state_d = S_HLT;
         default:  state_d = S_IF;
      endcase
   end

   // Control decode; everything reads 0 while Reset is held low
   always_comb begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      ExtSel    = 1'b0;
      RegDst    = 2'b00;
      RegWre    = 1'b0;
      WrRegDSrc = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = 3'b000;
      PCSrc     = 2'b00;
      mRD       = 1'b0;
      mWR       = 1'b0;
      DBDataSrc = 1'b0;
      if (Reset) begin
         ExtSel = !zero_ext;
         unique case (state_q)
            S_IF: begin
               IRWre    = 1'b1;
               InsMemRW = 1'b1;
            end
            S_ID: begin
               // Jumps and undefined opcodes retire here
               if (!is_halt && !is_branch && !is_ls && !is_alu) begin
                  PCWre = 1'b1;
                  if (Opcode == OP_J || Opcode == OP_JAL) PCSrc = 2'b11;
                  else if (Opcode == OP_JR)               PCSrc = 2'b10;
                  if (Opcode == OP_JAL) RegWre = 1'b1;
               end
            end
            S_EXE_AL, S_WB_AL: begin
               ALUSrcA   = (Opcode == OP_SLL);
               ALUSrcB   = uses_imm;
               ALUOp     = alu_dec;
               RegDst    = is_rtype ? 2'b10 : 2'b01;
               WrRegDSrc = 1'b1;
               if (state_q == S_WB_AL) begin
                  RegWre = 1'b1;
                  PCWre  = 1'b1;
               end
            end
            S_EXE_BR: begin
               ALUOp = 3'b001;
               PCWre = 1'b1;
               if ((Opcode == OP_BEQ  &&  Zero) ||
                   (Opcode == OP_BNE  && !Zero) ||
                   (Opcode == OP_BLTZ &&  Sign))
                  PCSrc = 2'b01;
            end
            S_EXE_LS, S_MEM, S_WB_L: begin
               ALUSrcB = 1'b1;
               ALUOp   = 3'b000;
               if (state_q == S_MEM) begin
                  mRD   = (Opcode == OP_LW);
                  mWR   = (Opcode == OP_SW);
                  PCWre = (Opcode == OP_SW);
               end
               if (state_q == S_WB_L) begin
                  mRD       = 1'b1;
                  RegDst    = 2'b01;
                  RegWre    = 1'b1;
                  WrRegDSrc = 1'b1;
                  DBDataSrc = 1'b1;
                  PCWre     = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its state sequence and checks the decoded controls against hand values.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       Reset;
   logic [5:0] Opcode;
   logic       Zero, Sign;
   logic       PCWre, IRWre, InsMemRW, ExtSel, RegWre, WrRegDSrc;
   logic       ALUSrcA, ALUSrcB, mRD, mWR, DBDataSrc;
   logic [1:0] RegDst, PCSrc;
   logic [2:0] ALUOp;
   logic [3:0] State;

   int n_cmp = 0;
   int n_err = 0;

   multicycle_ctrl #(.OP_W(6), .HALT_OP(6'b111111)) dut (
      .clk(clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .Sign(Sign),
      .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ExtSel(ExtSel),
      .RegDst(RegDst), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
      .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .State(State)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then let outputs settle away from the edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Enables packed as {PCWre, IRWre, InsMemRW, RegWre, mRD, mWR}
   task automatic chk_en(input string tag, input logic [5:0] exp);
      #1;
      chk(tag, 8'({PCWre, IRWre, InsMemRW, RegWre, mRD, mWR}), 8'(exp));
   endtask

   task automatic chk_st(input string tag, input logic [3:0] exp);
      chk(tag, 8'(State), 8'(exp));
   endtask

   initial begin
      Reset = 1'b0; Opcode = 6'b000000; Zero = 1'b0; Sign = 1'b0;
      tick(); tick();
      chk_st("por_state", 4'd0);
      chk_en("por_en", 6'b000000);
      Reset = 1'b1;
      chk_en("if_en", 6'b011000);

      // sw into MEM, then reset mid-instruction
      Opcode = 6'b110000;
      tick(); chk_st("sw_id", 4'd1); chk_en("sw_id_en", 6'b000000);
      tick(); chk_st("sw_exe", 4'd5);
      chk("sw_exe_alusrcb", 8'(ALUSrcB), 8'd1);
      tick(); chk_st("sw_mem", 4'd6); chk_en("sw_mem_en", 6'b100001);
      Reset = 1'b0;
      chk_en("rst_mem_en", 6'b000000);
      tick(); chk_st("rst_st1", 4'd0); chk_en("rst_en1", 6'b000000);
      tick(); chk_st("rst_st2", 4'd0); chk_en("rst_en2", 6'b000000);
      Reset = 1'b1;
      chk_en("rel_if_en", 6'b011000);

      // add: 0,1,2,3,0
      Opcode = 6'b000000;
      tick(); chk_st("add_id", 4'd1);
      tick(); chk_st("add_exe", 4'd2); chk_en("add_exe_en", 6'b000000);
      chk("add_exe_aluop", 8'(ALUOp), 8'd0);
      tick(); chk_st("add_wb", 4'd3); chk_en("add_wb_en", 6'b100100);
      chk("add_wb_regdst", 8'(RegDst), 8'd2);
      chk("add_wb_wrsrc", 8'({WrRegDSrc, DBDataSrc}), 8'b10);
      tick(); chk_st("add_done", 4'd0);

      // lw: 0,1,5,6,7,0
      Opcode = 6'b110001;
      tick(); chk_st("lw_id", 4'd1);
      tick(); chk_st("lw_exe", 4'd5);
      chk("lw_exe_aluop", 8'(ALUOp), 8'd0);
      tick(); chk_st("lw_mem", 4'd6); chk_en("lw_mem_en", 6'b000010);
      tick(); chk_st("lw_wb", 4'd7); chk_en("lw_wb_en", 6'b100110);
      chk("lw_wb_dbsrc", 8'(DBDataSrc), 8'd1);
      chk("lw_wb_regdst", 8'(RegDst), 8'd1);
      tick(); chk_st("lw_done", 4'd0);

      // sw complete: 0,1,5,6,0
      Opcode = 6'b110000;
      tick(); tick();
      tick(); chk_st("sw2_mem", 4'd6); chk_en("sw2_mem_en", 6'b100001);
      tick(); chk_st("sw2_done", 4'd0);

      // beq taken / not taken in EXE_BR
      Opcode = 6'b110100;
      tick(); chk_st("beq_id", 4'd1);
      tick(); chk_st("beq_exe", 4'd4);
      Zero = 1'b1; #1;
      chk("beq_z1_pcsrc", 8'(PCSrc), 8'd1); chk_en("beq_z1_en", 6'b100000);
      chk("beq_aluop", 8'(ALUOp), 8'd1);
      Zero = 1'b0; #1;
      chk("beq_z0_pcsrc", 8'(PCSrc), 8'd0); chk_en("beq_z0_en", 6'b100000);
      tick(); chk_st("beq_done", 4'd0);

      // bltz with Sign=1
      Opcode = 6'b110110;
      tick(); tick(); chk_st("bltz_exe", 4'd4);
      Sign = 1'b1; #1;
      chk("bltz_s1_pcsrc", 8'(PCSrc), 8'd1);
      Sign = 1'b0;
      tick(); chk_st("bltz_done", 4'd0);

      // jal: 0,1,0
      Opcode = 6'b111010;
      tick(); chk_st("jal_id", 4'd1); chk_en("jal_id_en", 6'b100100);
      chk("jal_regdst", 8'(RegDst), 8'd0);
      chk("jal_wrsrc", 8'(WrRegDSrc), 8'd0);
      chk("jal_pcsrc", 8'(PCSrc), 8'd3);
      tick(); chk_st("jal_done", 4'd0);

      // ori: zero-extend, immediate operand, I-type destination
      Opcode = 6'b010010;
      tick(); tick(); chk_st("ori_exe", 4'd2);
      chk("ori_ctl", 8'({ExtSel, ALUSrcA, ALUSrcB, ALUOp}), 8'b0_0_1_011);
      tick(); chk("ori_regdst", 8'(RegDst), 8'd1);
      tick(); chk_st("ori_done", 4'd0);

      // undefined opcode behaves as a one-cycle NOP in ID
      Opcode = 6'b000011;
      tick(); chk_st("nop_id", 4'd1); chk_en("nop_id_en", 6'b100000);
      chk("nop_pcsrc", 8'(PCSrc), 8'd0);
      tick(); chk_st("nop_done", 4'd0);

      // halt parks in HLT until reset
      Opcode = 6'b111111;
      tick(); chk_st("hlt_id", 4'd1); chk_en("hlt_id_en", 6'b000000);
      tick(); chk_st("hlt_enter", 4'd8);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_st("hlt_hold", 4'd8);
         chk_en("hlt_en", 6'b000000);
      end
      Reset = 1'b0;
      tick(); chk_st("hlt_rst", 4'd0);
      Reset = 1'b1;
      chk_en("hlt_rel_en", 6'b011000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
